mantissa_mul_pipe: RTL and testbench

Parametrised, pipelined successor of the fixed 28x28 mantissa Wallace-tree multiplier used in the posit FMA datapath. It accepts one operand pair per cycle through a valid/ready handshake and computes either one full-width product or packed SIMD sub-products, selected per transaction by op. The result feeds the FMA alignment/add stage. Pipeline depth is a parameter, and backpressure stalls the whole pipe.

---
 rtl/mantissa_mul_if.sv | 42 ++++
 rtl/mantissa_mul_pipe.sv | 152 +++++++++++++++
 tb/tb_mantissa_mul_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_mul_if.sv
// mantissa_mul_if
// Handshake bundle for the pipelined mantissa multiplier.
//   in_valid/in_ready : operand transfer (a, b, op)
//   out_valid/out_ready : result transfer (prod, op_out, err)
//   sticky : OR of discarded low product bits, present only when
//            MANTMUL_STICKY_EN is defined
// master = producer/consumer side (bench, FMA datapath); slave = multiplier.
interface mantissa_mul_if #(
    parameter int W = 28
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] prod;
    logic [1:0]     op_out;
    logic           err;
`ifdef MANTMUL_STICKY_EN
    logic           sticky;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, prod, op_out, err, sticky
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, prod, op_out, err, sticky
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, prod, op_out, err
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, prod, op_out, err
    );
`endif
endinterface

// File: rtl/mantissa_mul_pipe.sv
// mantissa_mul_pipe
// Pipelined W x W unsigned mantissa multiplier with packed SIMD modes.
//   op 00 : one W x W product
//   op 01 : two (W/2) x (W/2) lanes, each result in a W-bit field
//   op 10 : four (W/4) x (W/4) lanes, each result in a W/2-bit field
//   op 11 : reserved, result is zero with err set
// Ports: clk, rst (async, active high), bus (mantissa_mul_if.slave).
// Parameters: W (multiple of 4, >= 8), STAGES (1..4 register stages from
// accept to out_valid).
// Optional: define MANTMUL_STICKY_EN to add the sticky output.
//
// Stage 1 builds lane-masked partial products and reduces them to a
// carry-save pair; middle stages carry that pair forward; the output
// register performs the carry-propagate add. The stall is global: any
// held result freezes every stage.
module mantissa_mul_pipe #(
    parameter int W      = 28,
    parameter int STAGES = 3
) (
    input logic           clk,
    input logic           rst,
    mantissa_mul_if.slave bus
);
    localparam int H = W / 2;
    localparam int Q = W / 4;

    typedef struct packed {
        logic           v;
        logic [1:0]     op;
        logic [2*W-1:0] s;
        logic [2*W-1:0] c;
    } stage_t;

    logic           out_valid_q;
    logic [2*W-1:0] prod_q;
    logic [1:0]     op_out_q;
    logic           err_q;
    logic           stall;
    logic           accept;
    stage_t         head;
    stage_t         tail;
    logic [2*W-1:0] sum_full;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] csa_s;
    logic [2*W-1:0] csa_c;

    assign stall        = out_valid_q && !bus.out_ready;
    assign accept       = bus.in_valid && !stall;
    assign bus.in_ready = !stall;

    // Bits of a that may pair with b[j] without crossing a lane boundary.
    function automatic logic [W-1:0] lane_mask(input logic [1:0] m, input int j);
        logic [W-1:0] mk;
        mk = '0;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00:   mk[i] = 1'b1;
                2'b01:   mk[i] = ((i / H) == (j / H));
                2'b10:   mk[i] = ((i / Q) == (j / Q));
                default: mk[i] = 1'b0;
            endcase
        end
        return mk;
    endfunction

    // Partial-product generation and 3:2 carry-save reduction.
    always_comb begin
        pp    = '0;
        csa_s = '0;
        csa_c = '0;
        for (int j = 0; j < W; j++) begin
            pp = '0;
            if (accept && bus.b[j])
                pp = {{W{1'b0}}, bus.a & lane_mask(bus.op, j)} << j;
            {csa_s, csa_c} = {csa_s ^ csa_c ^ pp,
                              ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1};
        end
        head    = '0;
        head.v  = accept;
        head.op = accept ? bus.op : 2'b00;
        head.s  = csa_s;
        head.c  = csa_c;
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign tail = head;
        end else begin : g_pipe
            stage_t r [STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 1; i++)
                        r[i] <= '0;
                end else if (!stall) begin
                    r[0] <= head;
                    for (int i = 1; i < STAGES - 1; i++)
                        r[i] <= r[i-1];
                end
            end

            assign tail = r[STAGES-2];
        end
    endgenerate

    assign sum_full = tail.s + tail.c;

`ifdef MANTMUL_STICKY_EN
    logic sticky_q;
    logic sticky_next;

    // OR of the low half of every lane's product field.
    always_comb begin
        sticky_next = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            case (tail.op)
                2'b00:   if (i < W)       sticky_next = sticky_next | sum_full[i];
                2'b01:   if ((i % W) < H) sticky_next = sticky_next | sum_full[i];
                2'b10:   if ((i % H) < Q) sticky_next = sticky_next | sum_full[i];
                default: sticky_next = sticky_next;
            endcase
        end
    end

    assign bus.sticky = sticky_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            op_out_q    <= 2'b00;
            err_q       <= 1'b0;
`ifdef MANTMUL_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid_q <= tail.v;
            prod_q      <= sum_full;
            op_out_q    <= tail.op;
            err_q       <= tail.v && (tail.op == 2'b11);
`ifdef MANTMUL_STICKY_EN
            sticky_q    <= sticky_next;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;
    assign bus.op_out    = op_out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mantissa_mul_pipe.sv
// tb_mantissa_mul_pipe
// Directed and randomized bench for mantissa_mul_pipe. A monitor compares
// every completed output transfer with a lane-arithmetic reference model
// queued at input acceptance time.
module tb_mantissa_mul_pipe;
    localparam int W      = 28;
    localparam int H      = W / 2;
    localparam int Q      = W / 4;
    localparam int STAGES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mantissa_mul_if #(.W(W)) bus ();

    mantissa_mul_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_run  = 0;
    int ov_max  = 0;
    int xfers   = 0;

    typedef struct {
        logic [2*W-1:0] p;
        logic [1:0]     op;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [1:0] m);
        logic [2*W-1:0] r;
        logic [W-1:0]   lp;
        logic [H-1:0]   qp;
        r = '0;
        case (m)
            2'b00: r = (2*W)'(x) * (2*W)'(y);
            2'b01: for (int k = 0; k < 2; k++) begin
                lp = W'(x[k*H +: H]) * W'(y[k*H +: H]);
                r[k*W +: W] = lp;
            end
            2'b10: for (int k = 0; k < 4; k++) begin
                qp = H'(x[k*Q +: Q]) * H'(y[k*Q +: Q]);
                r[k*H +: H] = qp;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef MANTMUL_STICKY_EN
    function automatic logic ref_sticky(input logic [2*W-1:0] p, input logic [1:0] m);
        case (m)
            2'b00:   return |p[W-1:0];
            2'b01:   return (|p[H-1:0]) | (|p[W +: H]);
            2'b10:   return (|p[0 +: Q]) | (|p[H +: Q]) | (|p[2*H +: Q]) | (|p[3*H +: Q]);
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Monitor: at the falling edge, look at what the next rising edge will transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ov_run = 0;
        end else begin
            if (bus.out_valid) ov_run++;
            else ov_run = 0;
            if (ov_run > ov_max) ov_max = ov_run;
            if (bus.out_valid && bus.out_ready) begin
                xfers++;
                check("result_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("prod", 64'(bus.prod), 64'(e.p));
                    check("op_out", 64'(bus.op_out), 64'(e.op));
                    check("err", 64'(bus.err), 64'(e.op == 2'b11));
`ifdef MANTMUL_STICKY_EN
                    check("sticky", 64'(bus.sticky), 64'(ref_sticky(e.p, e.op)));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.p  = ref_prod(bus.a, bus.b, bus.op);
                e.op = bus.op;
                sb.push_back(e);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                        output int waits);
        bit done;
        waits = 0;
        done = 0;
        bus.in_valid = 1'b1;
        bus.a  = x;
        bus.b  = y;
        bus.op = m;
        while (!done && waits < 50) begin
            @(negedge clk);
            done = bus.in_ready;
            if (!done) waits++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_wait(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                             output int lat);
        int w;
        push(x, y, m, w);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [W-1:0]   ra, rb;
    logic [1:0]     rop;
    logic [2*W-1:0] frozen;
    int             lat, w, x0;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_prod", 64'(bus.prod), 64'd0);
        check("rst_op_out", 64'(bus.op_out), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
`ifdef MANTMUL_STICKY_EN
        check("rst_sticky", 64'(bus.sticky), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 1: full-width corner
        send_wait(28'hFFFFFFF, 28'hFFFFFFF, 2'b00, lat);
        check("t1_latency", 64'(lat), 64'(STAGES));
        check("t1_prod", 64'(bus.prod), 64'h00FFFFFFE0000001);
        check("t1_err", 64'(bus.err), 64'd0);
`ifdef MANTMUL_STICKY_EN
        check("t1_sticky", 64'(bus.sticky), 64'd1);
`endif
        idle(2);

        // 2: two lanes
        send_wait({14'h3FFF, 14'h3FFF}, {14'h3FFF, 14'h3FFF}, 2'b01, lat);
        check("t2a_lane0", 64'(bus.prod[27:0]), 64'h0FFF8001);
        check("t2a_lane1", 64'(bus.prod[55:28]), 64'h0FFF8001);
        idle(2);
        send_wait({14'h0001, 14'h3FFF}, {14'h0001, 14'h0002}, 2'b01, lat);
        check("t2b_lane0", 64'(bus.prod[27:0]), 64'h7FFE);
        check("t2b_lane1", 64'(bus.prod[55:28]), 64'h1);
        idle(2);

        // 3: four lanes, then reserved op
        send_wait(28'hFFFFFFF, 28'hFFFFFFF, 2'b10, lat);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_lane%0d", k), 64'(bus.prod[k*14 +: 14]), 64'h3F01);
        idle(2);
        send_wait(28'hFFFFFFF, 28'hFFFFFFF, 2'b11, lat);
        check("t3_rsv_prod", 64'(bus.prod), 64'd0);
        check("t3_rsv_err", 64'(bus.err), 64'd1);
        check("t3_rsv_op_out", 64'(bus.op_out), 64'd3);
        idle(4);

        // 4: back-to-back stream
        ov_max = 0;
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            push(W'(i), W'(i + 1), 2'b00, w);
            check("t4_in_ready_stall", 64'(w), 64'd0);
        end
        idle(STAGES + 3);
        check("t4_consecutive_valid", 64'(ov_max), 64'd10);
        check("t4_transfers", 64'(xfers - x0), 64'd10);

        // 5: random stream with a 5-cycle downstream hold once full
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom_range(0, 3));
            push(ra, rb, rop, w);
        end
        bus.out_ready = 1'b0;
        ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom_range(0, 2));
        bus.in_valid = 1'b1; bus.a = ra; bus.b = rb; bus.op = rop;
        check("t5_full_valid", 64'(bus.out_valid), 64'd1);
        frozen = bus.prod;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("t5_prod_frozen", 64'(bus.prod), 64'(frozen));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        push(ra, rb, rop, w);
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom_range(0, 3));
            push(ra, rb, rop, w);
        end
        idle(STAGES + 3);
        check("t5_drained", 64'(sb.size()), 64'd0);

        // 6: reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            push(ra, rb, 2'b00, w);
        end
        rst = 1'b1;
        #1;
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_prod", 64'(bus.prod), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);
        x0 = xfers;
        send_wait(28'h1234567, 28'h0ABCDEF, 2'b00, lat);
        check("t6_latency", 64'(lat), 64'(STAGES));
        idle(STAGES + 3);
        check("t6_transfers", 64'(xfers - x0), 64'd1);
        check("t6_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
